// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the sequential multi-word adder.
// Holds the FSM state encoding and the slice-index width helper.
package multiword_adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit combinational ripple-carry adder.
// Carry is walked bit by bit with a procedural variable, with no lookahead.
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multiword_adder_seq.sv
// Wide adder that streams one N-bit slice per clock through a single ripple_carry_adder.
// Operands and results move through valid/ready handshakes.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for an operand pair; in_ready high
//   RUN   | adding slice idx; carry chained between clocks
//   DONE  | sum/cout valid, held until out_ready
module multiword_adder_seq
    import multiword_adder_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          state, state_nxt;
    logic            rdy_q;
    logic [W-1:0]    a_sh, b_sh, sum_sh;
    logic            carry, cout_q;
    logic [IW-1:0]   idx;
    logic [N-1:0]    s_slice;
    logic            c_slice;
    logic [W+N-1:0]  sum_ext;
    logic            accept;

    ripple_carry_adder #(.N(N)) u_rca (
        .a    (a_sh[N-1:0]),
        .b    (b_sh[N-1:0]),
        .cin  (carry),
        .s    (s_slice),
        .cout (c_slice)
    );

    // New slice enters at the top so slice 0 ends up in the low bits after WORDS shifts.
    assign sum_ext = {s_slice, sum_sh};
    assign accept  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rdy_q;
                if (in_valid && rdy_q) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            idx    <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    carry  <= c_slice;
                    sum_sh <= sum_ext[W+N-1:N];
                    a_sh   <= a_sh >> N;
                    b_sh   <= b_sh >> N;
                    idx    <= idx + IW'(1);
                    if (idx == LAST) cout_q <= c_slice;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_sh;
    assign cout = cout_q;

endmodule
